// File: rtl/bench_run_ctrl_if.sv
// Debug-tap and status bundle between a mip32 core bench and its run controller.
// Wires only; all timing is set by the controller that drives the status side.
// No backpressure: the core taps are sampled every cycle.
interface bench_run_ctrl_if #(
   parameter int unsigned CNT_W = 32
) ();
   logic             start;
   logic [31:0]      pc;
   logic [31:0]      instr;
   logic             reg_we;
   logic [4:0]       reg_waddr;
   logic [31:0]      reg_wdata;
   logic             core_rst;
   logic             running;
   logic             done;
   logic             pass;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] wb_count;
   logic [31:0]      signature;

   modport master (
      output start, pc, instr, reg_we, reg_waddr, reg_wdata,
      input  core_rst, running, done, pass, timeout, cycle_count, wb_count, signature
   );

   modport slave (
      input  start, pc, instr, reg_we, reg_waddr, reg_wdata,
      output core_rst, running, done, pass, timeout, cycle_count, wb_count, signature
   );
endinterface

// File: rtl/bench_run_ctrl.sv
// Run controller for mip32 benches: core reset sequencing, halt/timeout detection, write signature.
// Status outputs are registered and update one edge after the observed tap cycle.
// No backpressure: taps are sampled every cycle; start is ignored while RST or RUN.
module bench_run_ctrl #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MAX_CYCLES  = 1000,
   parameter int unsigned RST_CYCLES  = 2,
   parameter int unsigned STALL_LIMIT = 4,
   parameter logic [31:0] HALT_WORD   = 32'h0000000C,
   parameter logic [31:0] EXPECT_SIG  = 32'h00000000
) (
   input logic             clk,
   input logic             reset,
   bench_run_ctrl_if.slave bus
);
   localparam int unsigned      RC_W     = $clog2(RST_CYCLES) + 1;
   localparam int unsigned      ST_W     = $clog2(STALL_LIMIT) + 1;
   localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
   // Repeat count already seen when the current repeat completes the self-loop.
   localparam logic [ST_W-1:0]  ST_HALT  = ST_W'(STALL_LIMIT - 2);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);

   typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic [ST_W-1:0]  stall_q, stall_d;
   logic [31:0]      prev_pc_q;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] wb_q, wb_d;
   logic [31:0]      sig_q, sig_d;
   logic             pass_q, pass_d;
   logic             timeout_q, timeout_d;
   logic             core_rst_q, running_q, done_q;
   logic             same_pc, halt, tmo;

   // Next-state and next-datapath values; everything holds unless a branch changes it.
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      stall_d   = stall_q;
      cyc_d     = cyc_q;
      wb_d      = wb_q;
      sig_d     = sig_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      same_pc   = 1'b0;
      halt      = 1'b0;
      tmo       = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d   = RST;
               rst_cnt_d = '0;
               stall_d   = '0;
               cyc_d     = '0;
               wb_d      = '0;
               sig_d     = '0;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
            end
         end
         RST: begin
            if (rst_cnt_q == RST_LAST) state_d = RUN;
            else                       rst_cnt_d = rst_cnt_q + 1'b1;
         end
         RUN: begin
            if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
            if (bus.reg_we && (bus.reg_waddr != 5'd0)) begin
               sig_d = {sig_q[30:0], sig_q[31]} ^ bus.reg_wdata ^ {27'b0, bus.reg_waddr};
               if (wb_q != '1) wb_d = wb_q + 1'b1;
            end
            // The first RUN cycle has no meaningful previous pc, so it never counts as a repeat.
            same_pc = (cyc_q != '0) && (bus.pc == prev_pc_q);
            stall_d = same_pc ? stall_q + 1'b1 : '0;
            halt    = (bus.instr == HALT_WORD) || (same_pc && (stall_q == ST_HALT));
            tmo     = !halt && (cyc_d >= MAX_C);
            if (halt || tmo) begin
               state_d   = DONE;
               timeout_d = tmo;
               pass_d    = !tmo && (sig_d == EXPECT_SIG);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath and registered status outputs, all derived from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_cnt_q  <= '0;
         stall_q    <= '0;
         prev_pc_q  <= '0;
         cyc_q      <= '0;
         wb_q       <= '0;
         sig_q      <= '0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         core_rst_q <= 1'b1;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rst_cnt_q  <= rst_cnt_d;
         stall_q    <= stall_d;
         prev_pc_q  <= bus.pc;
         cyc_q      <= cyc_d;
         wb_q       <= wb_d;
         sig_q      <= sig_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         core_rst_q <= (state_d != RUN);
         running_q  <= (state_d == RUN);
         done_q     <= (state_d == DONE);
      end
   end

   assign bus.core_rst    = core_rst_q;
   assign bus.running     = running_q;
   assign bus.done        = done_q;
   assign bus.pass        = pass_q;
   assign bus.timeout     = timeout_q;
   assign bus.cycle_count = cyc_q;
   assign bus.wb_count    = wb_q;
   assign bus.signature   = sig_q;
endmodule

// File: tb/tb_bench_run_ctrl.sv
// Bench for bench_run_ctrl: two instances differing only in golden signature share one stimulus.
// Each scenario loads a RUN-cycle program table, runs it, and checks against a run-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_bench_run_ctrl;
   localparam int          MAXC   = 40;
   localparam int          STALL  = 4;
   localparam logic [31:0] HALT   = 32'h0000000C;
   localparam logic [31:0] SIG_A  = 32'h0000000D;   // ROTL(5^1)^7^2 under the fold rule
   localparam logic [31:0] SIG_B  = 32'h00000000;
   localparam int          PLEN   = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] instr = '0;
   logic        reg_we = 1'b0;
   logic [4:0]  reg_waddr = '0;
   logic [31:0] reg_wdata = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] p_pc [PLEN];
   logic [31:0] p_in [PLEN];
   logic        p_we [PLEN];
   logic [4:0]  p_wa [PLEN];
   logic [31:0] p_wd [PLEN];

   bench_run_ctrl_if #(.CNT_W(32)) ifa ();
   bench_run_ctrl_if #(.CNT_W(32)) ifb ();

   assign ifa.start = start;  assign ifb.start = start;
   assign ifa.pc = pc;        assign ifb.pc = pc;
   assign ifa.instr = instr;  assign ifb.instr = instr;
   assign ifa.reg_we = reg_we;       assign ifb.reg_we = reg_we;
   assign ifa.reg_waddr = reg_waddr; assign ifb.reg_waddr = reg_waddr;
   assign ifa.reg_wdata = reg_wdata; assign ifb.reg_wdata = reg_wdata;

   bench_run_ctrl #(.CNT_W(32), .MAX_CYCLES(MAXC), .RST_CYCLES(2), .STALL_LIMIT(STALL),
                    .HALT_WORD(HALT), .EXPECT_SIG(SIG_A))
      dut_a (.clk(clk), .reset(reset), .bus(ifa));
   bench_run_ctrl #(.CNT_W(32), .MAX_CYCLES(MAXC), .RST_CYCLES(2), .STALL_LIMIT(STALL),
                    .HALT_WORD(HALT), .EXPECT_SIG(SIG_B))
      dut_b (.clk(clk), .reset(reset), .bus(ifb));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; pc = '0; instr = '0; reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
   endtask

   // Default program: ever-changing pc, no halt, no writes.
   task automatic clear_prog();
      for (int i = 0; i < PLEN; i++) begin
         p_pc[i] = 32'h100 + 32'(4 * i); p_in[i] = '0; p_we[i] = 1'b0; p_wa[i] = '0; p_wd[i] = '0;
      end
   endtask

   task automatic set_ent(input int i, input logic [31:0] a, input logic [31:0] ins,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd);
      p_pc[i] = a; p_in[i] = ins; p_we[i] = we; p_wa[i] = wa; p_wd[i] = wd;
   endtask

   task automatic build_halt_prog();
      clear_prog();
      set_ent(0, 32'h0, 32'h1, 1'b1, 5'd1, 32'd5);
      set_ent(1, 32'h4, 32'h2, 1'b1, 5'd2, 32'd7);
      set_ent(2, 32'h8, HALT, 1'b0, 5'd0, 32'd0);
   endtask

   // Run-level reference: walk the program cycle by cycle applying the end-of-program rules.
   task automatic model_run(output int e_len, output logic [31:0] e_sig, output int e_wb,
                            output logic e_tmo);
      int          run_len;
      logic [31:0] prev;
      e_sig = '0; e_wb = 0; e_tmo = 1'b1; e_len = MAXC; run_len = 0; prev = '0;
      for (int i = 0; i < MAXC; i++) begin
         if (p_we[i] && p_wa[i] != 5'd0) begin
            e_sig = {e_sig[30:0], e_sig[31]} ^ p_wd[i] ^ {27'b0, p_wa[i]};
            e_wb++;
         end
         run_len = (i > 0 && p_pc[i] == prev) ? run_len + 1 : 1;
         prev = p_pc[i];
         if (p_in[i] == HALT || run_len >= STALL) begin
            e_len = i + 1; e_tmo = 1'b0;
            return;
         end
      end
   endtask

   // Start, measure core_rst length, feed the program until done or the cycle budget expires.
   task automatic run_prog(input int start_at, output int rst_hi, output int run_cyc,
                           output logic got_done);
      idle_inputs();
      start = 1'b1;
      step();
      start = 1'b0;
      rst_hi = 0;
      while (ifa.core_rst && rst_hi < 10) begin
         rst_hi++;
         step();
      end
      got_done = 1'b0; run_cyc = 0;
      for (int i = 0; i < MAXC + 5 && !got_done; i++) begin
         pc = p_pc[i]; instr = p_in[i]; reg_we = p_we[i]; reg_waddr = p_wa[i]; reg_wdata = p_wd[i];
         start = (i == start_at);
         step();
         run_cyc = i + 1;
         if (ifa.done) got_done = 1'b1;
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      checks++; if (ifa.core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst got %b exp 1", ifa.core_rst); end
      checks++; if (ifa.done !== 1'b0 || ifa.running !== 1'b0) begin errors++; $display("FAIL rst_done_running got %b%b exp 00", ifa.done, ifa.running); end
      checks++; if (ifa.pass !== 1'b0 || ifa.timeout !== 1'b0) begin errors++; $display("FAIL rst_pass_tmo got %b%b exp 00", ifa.pass, ifa.timeout); end
      checks++; if (ifa.cycle_count !== 32'd0 || ifa.wb_count !== 32'd0 || ifa.signature !== 32'd0) begin errors++; $display("FAIL rst_counters got %0d %0d %h exp 0 0 0", ifa.cycle_count, ifa.wb_count, ifa.signature); end
      repeat (5) step();
      checks++; if (ifa.core_rst !== 1'b1 || ifa.running !== 1'b0 || ifb.core_rst !== 1'b1) begin errors++; $display("FAIL idle_hold got core_rst %b running %b exp 1 0", ifa.core_rst, ifa.running); end
   endtask

   task automatic test_halt_word();
      int rh, rc, e_len, e_wb; logic gd, e_tmo; logic [31:0] e_sig;
      build_halt_prog();
      model_run(e_len, e_sig, e_wb, e_tmo);
      run_prog(-1, rh, rc, gd);
      checks++; if (rh !== 2) begin errors++; $display("FAIL halt_core_rst_len got %0d exp 2", rh); end
      checks++; if (gd !== 1'b1 || rc !== 3) begin errors++; $display("FAIL halt_done got %b at %0d exp 1 at 3", gd, rc); end
      checks++; if (ifa.timeout !== 1'b0 || ifa.wb_count !== 32'd2) begin errors++; $display("FAIL halt_tmo_wb got %b %0d exp 0 2", ifa.timeout, ifa.wb_count); end
      checks++; if (ifa.signature !== 32'h0000000D || ifa.signature !== e_sig) begin errors++; $display("FAIL halt_sig got %h exp %h", ifa.signature, e_sig); end
      checks++; if (ifa.pass !== 1'b1) begin errors++; $display("FAIL halt_pass_a got %b exp 1", ifa.pass); end
      checks++; if (ifb.pass !== 1'b0 || ifb.timeout !== 1'b0) begin errors++; $display("FAIL halt_pass_b got %b %b exp 0 0", ifb.pass, ifb.timeout); end
      checks++; if (ifa.core_rst !== 1'b1 || ifa.running !== 1'b0 || ifa.cycle_count !== 32'd3) begin errors++; $display("FAIL halt_frozen got %b %b %0d exp 1 0 3", ifa.core_rst, ifa.running, ifa.cycle_count); end
   endtask

   task automatic test_stall_halt();
      int rh, rc, e_len, e_wb; logic gd, e_tmo; logic [31:0] e_sig;
      clear_prog();
      set_ent(0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0);
      set_ent(1, 32'h4, 32'h0, 1'b0, 5'd0, 32'd0);
      for (int i = 2; i < 6; i++) set_ent(i, 32'h40, 32'h0, 1'b0, 5'd0, 32'd0);
      model_run(e_len, e_sig, e_wb, e_tmo);
      run_prog(-1, rh, rc, gd);
      checks++; if (gd !== 1'b1 || rc !== 6 || rc !== e_len) begin errors++; $display("FAIL stall_done got %b at %0d exp 1 at 6", gd, rc); end
      checks++; if (ifa.cycle_count !== 32'd6 || ifa.timeout !== 1'b0) begin errors++; $display("FAIL stall_count got %0d %b exp 6 0", ifa.cycle_count, ifa.timeout); end
      checks++; if (ifa.pass !== 1'b0 || ifb.pass !== 1'b1) begin errors++; $display("FAIL stall_pass got %b %b exp 0 1", ifa.pass, ifb.pass); end
   endtask

   task automatic test_timeout();
      int rh, rc; logic gd;
      clear_prog();
      run_prog(-1, rh, rc, gd);
      checks++; if (gd !== 1'b1 || rc !== MAXC) begin errors++; $display("FAIL tmo_done got %b at %0d exp 1 at %0d", gd, rc, MAXC); end
      checks++; if (ifa.timeout !== 1'b1 || ifb.timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b %b exp 1 1", ifa.timeout, ifb.timeout); end
      checks++; if (ifa.pass !== 1'b0 || ifb.pass !== 1'b0) begin errors++; $display("FAIL tmo_pass got %b %b exp 0 0", ifa.pass, ifb.pass); end
      checks++; if (ifa.cycle_count !== 32'(MAXC)) begin errors++; $display("FAIL tmo_count got %0d exp %0d", ifa.cycle_count, MAXC); end
   endtask

   task automatic test_r0_and_start();
      int rh, rc, e_len, e_wb; logic gd, e_tmo; logic [31:0] e_sig;
      clear_prog();
      set_ent(0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
      set_ent(1, 32'h4, 32'h0, 1'b1, 5'd3, 32'd9);
      set_ent(2, 32'h8, 32'h0, 1'b1, 5'd0, 32'd1);
      set_ent(3, 32'hC, HALT, 1'b0, 5'd0, 32'd0);
      model_run(e_len, e_sig, e_wb, e_tmo);
      run_prog(1, rh, rc, gd);
      checks++; if (gd !== 1'b1 || rc !== 4 || rc !== e_len) begin errors++; $display("FAIL r0_done got %b at %0d exp 1 at 4", gd, rc); end
      checks++; if (ifa.wb_count !== 32'd1 || ifa.signature !== 32'h0000000A || ifa.signature !== e_sig) begin errors++; $display("FAIL r0_writes got %0d %h exp 1 0000000a", ifa.wb_count, ifa.signature); end
   endtask

   task automatic test_reset_mid_run();
      int rh, rc; logic gd;
      clear_prog();
      for (int i = 0; i < 6; i++) set_ent(i, 32'h200 + 32'(4 * i), 32'h0, 1'b1, 5'(i + 1), 32'h1111 * 32'(i + 1));
      start = 1'b1; step(); start = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 6; i++) begin
         pc = p_pc[i]; instr = p_in[i]; reg_we = p_we[i]; reg_waddr = p_wa[i]; reg_wdata = p_wd[i];
         step();
      end
      checks++; if (ifa.running !== 1'b1 || ifa.wb_count !== 32'd6) begin errors++; $display("FAIL mid_pre got running %b wb %0d exp 1 6", ifa.running, ifa.wb_count); end
      #1 reset = 1'b0;
      #1;
      checks++; if (ifa.core_rst !== 1'b1 || ifa.running !== 1'b0 || ifa.done !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl got %b %b %b exp 1 0 0", ifa.core_rst, ifa.running, ifa.done); end
      checks++; if (ifa.cycle_count !== 32'd0 || ifa.wb_count !== 32'd0 || ifa.signature !== 32'd0 || ifb.pass !== 1'b0) begin errors++; $display("FAIL mid_rst_data got %0d %0d %h exp 0 0 0", ifa.cycle_count, ifa.wb_count, ifa.signature); end
      idle_inputs();
      step();
      reset = 1'b1;
      step();
      build_halt_prog();
      run_prog(-1, rh, rc, gd);
      checks++; if (gd !== 1'b1 || ifa.signature !== SIG_A || ifa.pass !== 1'b1 || ifa.wb_count !== 32'd2) begin errors++; $display("FAIL mid_rerun got done %b sig %h pass %b wb %0d exp 1 %h 1 2", gd, ifa.signature, ifa.pass, ifa.wb_count, SIG_A); end
   endtask

   task automatic test_random();
      int rh, rc, e_len, e_wb, len; logic gd, e_tmo; logic [31:0] e_sig, s_sig, s_wb, s_cyc;
      for (int it = 0; it < 24; it++) begin
         clear_prog();
         len = $urandom_range(1, 30);
         for (int i = 0; i < len; i++) begin
            p_pc[i] = (i > 0 && $urandom_range(0, 2) == 0) ? p_pc[i-1] : 32'($urandom_range(0, 7) * 4);
            p_in[i] = ($urandom_range(0, 19) == 0) ? HALT : $urandom;
            p_we[i] = 1'($urandom_range(0, 1));
            p_wa[i] = 5'($urandom_range(0, 31));
            p_wd[i] = $urandom;
         end
         model_run(e_len, e_sig, e_wb, e_tmo);
         run_prog(-1, rh, rc, gd);
         checks++; if (gd !== 1'b1 || rc !== e_len || ifa.cycle_count !== 32'(e_len)) begin errors++; $display("FAIL rnd%0d_len got %b %0d %0d exp 1 %0d", it, gd, rc, ifa.cycle_count, e_len); end
         checks++; if (ifa.signature !== e_sig || ifa.wb_count !== 32'(e_wb)) begin errors++; $display("FAIL rnd%0d_sig got %h %0d exp %h %0d", it, ifa.signature, ifa.wb_count, e_sig, e_wb); end
         checks++; if (ifa.timeout !== e_tmo || ifa.pass !== (!e_tmo && e_sig == SIG_A) || ifb.pass !== (!e_tmo && e_sig == SIG_B)) begin errors++; $display("FAIL rnd%0d_verdict got tmo %b pass %b %b exp tmo %b", it, ifa.timeout, ifa.pass, ifb.pass, e_tmo); end
         s_sig = ifa.signature; s_wb = ifa.wb_count; s_cyc = ifa.cycle_count;
         for (int k = 0; k < 3; k++) begin
            pc = 32'h80; reg_we = 1'b1; reg_waddr = 5'd7; reg_wdata = $urandom;
            step();
         end
         idle_inputs();
         checks++; if (ifa.done !== 1'b1 || ifa.signature !== s_sig || ifa.wb_count !== s_wb || ifa.cycle_count !== s_cyc) begin errors++; $display("FAIL rnd%0d_freeze got done %b sig %h wb %0d cyc %0d exp 1 %h %0d %0d", it, ifa.done, ifa.signature, ifa.wb_count, ifa.cycle_count, s_sig, s_wb, s_cyc); end
      end
   endtask

   initial begin
      clear_prog();
      test_reset();
      test_halt_word();
      test_stall_halt();
      test_timeout();
      test_r0_and_start();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
